// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle CPU control unit.
// Covers opcode/ALU encodings, FSM state encoding and the decode payload.
package cpu_pkg;

  localparam int unsigned PC_W  = 13;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned ALU_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_ADDI = 3'b100,
    OP_LW   = 3'b101,
    OP_SW   = 3'b110,
    OP_BEQ  = 3'b111
  } opcode_e;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_FAULT   = 3'd6
  } state_e;

  // Control fields derived from the latched opcode.
  typedef struct packed {
    logic [ALU_W-1:0] alu_op;
    logic             instr_type;
    logic             is_mem;
    logic             is_load;
    logic             is_branch;
    logic             writes_reg;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps an opcode onto ALU operation,
// B-operand select and instruction-class flags.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output dec_t            dec_c
);

  always_comb begin
    dec_c = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        dec_c.alu_op     = {1'b0, op[1:0]};
        dec_c.instr_type = 1'b1;
        dec_c.writes_reg = 1'b1;
      end
      OP_ADDI: begin
        dec_c.alu_op     = ALU_ADD;
        dec_c.writes_reg = 1'b1;
      end
      OP_LW: begin
        dec_c.alu_op     = ALU_ADD;
        dec_c.is_mem     = 1'b1;
        dec_c.is_load    = 1'b1;
        dec_c.writes_reg = 1'b1;
      end
      OP_SW: begin
        dec_c.alu_op = ALU_ADD;
        dec_c.is_mem = 1'b1;
      end
      OP_BEQ: begin
        dec_c.alu_op     = ALU_SUB;
        dec_c.instr_type = 1'b1;
        dec_c.is_branch  = 1'b1;
      end
      default: dec_c = '0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control FSM: owns the PC, sequences fetch/decode/execute/
// mem/writeback, and guards memory handshakes with a watchdog.
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned RET_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [OP_W-1:0]   Opcode,
  input  logic              memDone,
  input  logic              BEQ,
  input  logic [PC_W-1:0]   newPC,
  output logic              read,
  output logic              write,
  output logic              instruction,
  output logic              instructionType,
  output logic [ALU_W-1:0]  ALU_Op,
  output logic              writeFlag,
  output logic [PC_W-1:0]   PC,
  output logic              busy,
  output logic              fault,
  output logic [RET_W-1:0]  retired
);

  localparam int unsigned WD_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [RET_W-1:0]  ret_q, ret_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              instr_q, instr_d;
  logic              itype_q, itype_d;
  logic [ALU_W-1:0]  alu_q, alu_d;
  logic              wflag_q, wflag_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;
  logic              boundary;
  logic              wait_mem;
  dec_t              dec_c;

  // Opcode is captured only while in DECODE; decoding the next value lets
  // registered outputs line up with the state they belong to.
  assign op_d = (state_q == ST_DECODE) ? Opcode : op_q;

  ctrl_decode u_decode (
    .op    (op_d),
    .dec_c (dec_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      pc_q    <= '0;
      ret_q   <= '0;
      wd_q    <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      instr_q <= 1'b0;
      itype_q <= 1'b0;
      alu_q   <= '0;
      wflag_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      wd_q    <= wd_d;
      read_q  <= read_d;
      write_q <= write_d;
      instr_q <= instr_d;
      itype_q <= itype_d;
      alu_q   <= alu_d;
      wflag_q <= wflag_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  // Next state, PC, retire count and watchdog.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ret_d    = ret_q;
    wd_d     = wd_q;
    boundary = 1'b0;
    wait_mem = 1'b0;
    case (state_q)
      ST_IDLE:    if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        wait_mem = 1'b1;
        if (memDone) state_d = ST_DECODE;
      end
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (dec_c.is_branch) begin
          pc_d     = BEQ ? newPC : pc_q + PC_W'(1);
          boundary = 1'b1;
        end else if (dec_c.is_mem) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        wait_mem = 1'b1;
        if (memDone) begin
          if (dec_c.is_load) begin
            state_d = ST_WB;
          end else begin
            pc_d     = pc_q + PC_W'(1);
            boundary = 1'b1;
          end
        end
      end
      ST_WB: begin
        pc_d     = pc_q + PC_W'(1);
        boundary = 1'b1;
      end
      ST_FAULT:   state_d = ST_FAULT;
      default:    state_d = ST_IDLE;
    endcase

    if (boundary) begin
      ret_d   = ret_q + RET_W'(1);
      state_d = run ? ST_FETCH : ST_IDLE;
    end

    // A memDone in the limit cycle has already completed the access above.
    if (wait_mem && !memDone && (wd_q == WD_W'(MEM_TIMEOUT - 1))) begin
      state_d = ST_FAULT;
    end

    if ((state_d != state_q) || !wait_mem || memDone) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  // Outputs for the upcoming state, registered alongside it.
  always_comb begin
    read_d  = 1'b0;
    write_d = 1'b0;
    instr_d = 1'b0;
    itype_d = 1'b0;
    alu_d   = '0;
    wflag_d = 1'b0;
    busy_d  = (state_d != ST_IDLE) && (state_d != ST_FAULT);
    fault_d = fault_q || (state_d == ST_FAULT);
    case (state_d)
      ST_FETCH: begin
        read_d  = 1'b1;
        instr_d = 1'b1;
      end
      ST_EXECUTE: begin
        alu_d   = dec_c.alu_op;
        itype_d = dec_c.instr_type;
      end
      ST_MEM: begin
        alu_d   = dec_c.alu_op;
        itype_d = dec_c.instr_type;
        read_d  = dec_c.is_load;
        write_d = !dec_c.is_load;
      end
      ST_WB: begin
        alu_d   = dec_c.alu_op;
        itype_d = dec_c.instr_type;
        wflag_d = dec_c.writes_reg;
      end
      default: ;
    endcase
  end

  assign read            = read_q;
  assign write           = write_q;
  assign instruction     = instr_q;
  assign instructionType = itype_q;
  assign ALU_Op          = alu_q;
  assign writeFlag       = wflag_q;
  assign PC              = pc_q;
  assign busy            = busy_q;
  assign fault           = fault_q;
  assign retired         = ret_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed, table-driven bench for cpu_control_fsm with hand-written
// sequences for reset, watchdog timeout and fault stickiness.
module tb_cpu_control_fsm;
  import cpu_pkg::*;

  localparam int unsigned RET_W   = 16;
  localparam int unsigned TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              reset, run, memDone, BEQ;
  logic [OP_W-1:0]   Opcode;
  logic [PC_W-1:0]   newPC;
  logic              read, write, instruction, instructionType, writeFlag, busy, fault;
  logic [ALU_W-1:0]  ALU_Op;
  logic [PC_W-1:0]   PC;
  logic [RET_W-1:0]  retired;

  typedef struct packed {
    logic             rd;
    logic             wr;
    logic             ins;
    logic             it;
    logic [ALU_W-1:0] alu;
    logic             wf;
    logic             busy;
    logic             flt;
    logic [PC_W-1:0]  pc;
    logic [RET_W-1:0] ret;
  } out_t;

  typedef struct {
    logic             run;
    logic [OP_W-1:0]  op;
    logic             md;
    logic             beq;
    logic [PC_W-1:0]  npc;
    out_t             exp;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  cpu_control_fsm #(.MEM_TIMEOUT(TIMEOUT), .RET_W(RET_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .run             (run),
    .Opcode          (Opcode),
    .memDone         (memDone),
    .BEQ             (BEQ),
    .newPC           (newPC),
    .read            (read),
    .write           (write),
    .instruction     (instruction),
    .instructionType (instructionType),
    .ALU_Op          (ALU_Op),
    .writeFlag       (writeFlag),
    .PC              (PC),
    .busy            (busy),
    .fault           (fault),
    .retired         (retired)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(logic rd, logic wr, logic ins, logic it, logic [ALU_W-1:0] alu,
                              logic wf, logic bsy, logic flt, logic [PC_W-1:0] pc,
                              logic [RET_W-1:0] ret);
    out_t o;
    o = '{rd, wr, ins, it, alu, wf, bsy, flt, pc, ret};
    return o;
  endfunction

  function automatic out_t e_idle(logic [PC_W-1:0] pc, logic [RET_W-1:0] ret);
    return mk(0, 0, 0, 0, 3'd0, 0, 0, 0, pc, ret);
  endfunction
  function automatic out_t e_fetch(logic [PC_W-1:0] pc, logic [RET_W-1:0] ret);
    return mk(1, 0, 1, 0, 3'd0, 0, 1, 0, pc, ret);
  endfunction
  function automatic out_t e_dec(logic [PC_W-1:0] pc, logic [RET_W-1:0] ret);
    return mk(0, 0, 0, 0, 3'd0, 0, 1, 0, pc, ret);
  endfunction
  function automatic out_t e_exe(logic [ALU_W-1:0] alu, logic it, logic [PC_W-1:0] pc,
                                 logic [RET_W-1:0] ret);
    return mk(0, 0, 0, it, alu, 0, 1, 0, pc, ret);
  endfunction
  function automatic out_t e_mrd(logic [PC_W-1:0] pc, logic [RET_W-1:0] ret);
    return mk(1, 0, 0, 0, 3'd0, 0, 1, 0, pc, ret);
  endfunction
  function automatic out_t e_mwr(logic [PC_W-1:0] pc, logic [RET_W-1:0] ret);
    return mk(0, 1, 0, 0, 3'd0, 0, 1, 0, pc, ret);
  endfunction
  function automatic out_t e_wb(logic [ALU_W-1:0] alu, logic it, logic [PC_W-1:0] pc,
                                logic [RET_W-1:0] ret);
    return mk(0, 0, 0, it, alu, 1, 1, 0, pc, ret);
  endfunction

  function automatic void add(logic r, logic [OP_W-1:0] op, logic md, logic beq,
                              logic [PC_W-1:0] npc, out_t e);
    vec_t v;
    v.run = r; v.op = op; v.md = md; v.beq = beq; v.npc = npc; v.exp = e;
    tbl.push_back(v);
  endfunction

  function automatic out_t sample();
    out_t o;
    o = {read, write, instruction, instructionType, ALU_Op, writeFlag, busy, fault, PC, retired};
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rd=%0b wr=%0b ins=%0b it=%0b alu=%0d wf=%0b busy=%0b flt=%0b pc=%0h ret=%0d | want rd=%0b wr=%0b ins=%0b it=%0b alu=%0d wf=%0b busy=%0b flt=%0b pc=%0h ret=%0d",
               name, act.rd, act.wr, act.ins, act.it, act.alu, act.wf, act.busy, act.flt,
               act.pc, act.ret, exp.rd, exp.wr, exp.ins, exp.it, exp.alu, exp.wf, exp.busy,
               exp.flt, exp.pc, exp.ret);
    end
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; Opcode = '0; memDone = 1'b0; BEQ = 1'b0; newPC = '0;

    // Each row: inputs present for one cycle, then outputs after the edge.
    add(0, 3'b000, 0, 0, 13'h0,    e_idle(13'h0, 16'd0));
    // ADDI with memDone on the third fetch cycle
    add(1, 3'b000, 0, 0, 13'h0,    e_fetch(13'h0, 16'd0));
    add(1, 3'b000, 0, 0, 13'h0,    e_fetch(13'h0, 16'd0));
    add(1, 3'b000, 0, 0, 13'h0,    e_fetch(13'h0, 16'd0));
    add(1, 3'b000, 1, 0, 13'h0,    e_dec(13'h0, 16'd0));
    add(1, 3'b100, 0, 0, 13'h0,    e_exe(3'd0, 0, 13'h0, 16'd0));
    add(1, 3'b000, 0, 0, 13'h0,    e_wb(3'd0, 0, 13'h0, 16'd0));
    add(1, 3'b000, 0, 0, 13'h0,    e_fetch(13'h1, 16'd1));
    // LW; memDone during DECODE/EXECUTE is ignored
    add(1, 3'b000, 1, 0, 13'h0,    e_dec(13'h1, 16'd1));
    add(1, 3'b101, 1, 0, 13'h0,    e_exe(3'd0, 0, 13'h1, 16'd1));
    add(1, 3'b000, 1, 0, 13'h0,    e_mrd(13'h1, 16'd1));
    add(1, 3'b000, 1, 0, 13'h0,    e_wb(3'd0, 0, 13'h1, 16'd1));
    add(1, 3'b000, 0, 0, 13'h0,    e_fetch(13'h2, 16'd2));
    // SW, no writeback
    add(1, 3'b000, 1, 0, 13'h0,    e_dec(13'h2, 16'd2));
    add(1, 3'b110, 0, 0, 13'h0,    e_exe(3'd0, 0, 13'h2, 16'd2));
    add(1, 3'b000, 0, 0, 13'h0,    e_mwr(13'h2, 16'd2));
    add(1, 3'b000, 0, 0, 13'h0,    e_mwr(13'h2, 16'd2));
    add(1, 3'b000, 1, 0, 13'h0,    e_fetch(13'h3, 16'd3));
    // OR then AND
    add(1, 3'b000, 1, 0, 13'h0,    e_dec(13'h3, 16'd3));
    add(1, 3'b011, 0, 0, 13'h0,    e_exe(3'd3, 1, 13'h3, 16'd3));
    add(1, 3'b000, 0, 0, 13'h0,    e_wb(3'd3, 1, 13'h3, 16'd3));
    add(1, 3'b000, 0, 0, 13'h0,    e_fetch(13'h4, 16'd4));
    add(1, 3'b000, 1, 0, 13'h0,    e_dec(13'h4, 16'd4));
    add(1, 3'b010, 0, 0, 13'h0,    e_exe(3'd2, 1, 13'h4, 16'd4));
    add(1, 3'b000, 0, 0, 13'h0,    e_wb(3'd2, 1, 13'h4, 16'd4));
    add(1, 3'b000, 0, 0, 13'h0,    e_fetch(13'h5, 16'd5));
    // BEQ not taken at 5, taken back to 5, taken to 0x100
    add(1, 3'b000, 1, 0, 13'h0,    e_dec(13'h5, 16'd5));
    add(1, 3'b111, 0, 0, 13'h0,    e_exe(3'd1, 1, 13'h5, 16'd5));
    add(1, 3'b000, 0, 0, 13'h100,  e_fetch(13'h6, 16'd6));
    add(1, 3'b000, 1, 0, 13'h0,    e_dec(13'h6, 16'd6));
    add(1, 3'b111, 0, 0, 13'h0,    e_exe(3'd1, 1, 13'h6, 16'd6));
    add(1, 3'b000, 0, 1, 13'h5,    e_fetch(13'h5, 16'd7));
    add(1, 3'b000, 1, 0, 13'h0,    e_dec(13'h5, 16'd7));
    add(1, 3'b111, 0, 0, 13'h0,    e_exe(3'd1, 1, 13'h5, 16'd7));
    add(1, 3'b000, 0, 1, 13'h100,  e_fetch(13'h100, 16'd8));
    // jump to 8191, then ADD wraps PC with run dropped during EXECUTE
    add(1, 3'b000, 1, 0, 13'h0,    e_dec(13'h100, 16'd8));
    add(1, 3'b111, 0, 0, 13'h0,    e_exe(3'd1, 1, 13'h100, 16'd8));
    add(1, 3'b000, 0, 1, 13'h1FFF, e_fetch(13'h1FFF, 16'd9));
    add(1, 3'b000, 1, 0, 13'h0,    e_dec(13'h1FFF, 16'd9));
    add(1, 3'b000, 0, 0, 13'h0,    e_exe(3'd0, 1, 13'h1FFF, 16'd9));
    add(0, 3'b000, 0, 0, 13'h0,    e_wb(3'd0, 1, 13'h1FFF, 16'd9));
    add(0, 3'b000, 0, 0, 13'h0,    e_idle(13'h0, 16'd10));
    add(0, 3'b000, 1, 0, 13'h0,    e_idle(13'h0, 16'd10));

    // Reset, then asynchronous reset in the middle of a fetch
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", e_idle(13'h0, 16'd0));
    reset = 1'b1; run = 1'b1;
    step();
    check("first_fetch", e_fetch(13'h0, 16'd0));
    #2 reset = 1'b0;
    #1 check("async_reset_mid_fetch", e_idle(13'h0, 16'd0));
    run = 1'b0; reset = 1'b1;
    step();
    check("idle_after_release", e_idle(13'h0, 16'd0));
    step();
    check("idle_stays", e_idle(13'h0, 16'd0));

    foreach (tbl[i]) begin
      run = tbl[i].run; Opcode = tbl[i].op; memDone = tbl[i].md;
      BEQ = tbl[i].beq; newPC = tbl[i].npc;
      step();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end
    BEQ = 1'b0; newPC = '0; Opcode = '0; memDone = 1'b0;

    // memDone arriving in the limit cycle of FETCH completes the access
    run = 1'b1;
    step();
    check("wd_fetch_enter", e_fetch(13'h0, 16'd10));
    for (int k = 1; k < TIMEOUT; k++) step();
    check("wd_fetch_cycle64", e_fetch(13'h0, 16'd10));
    memDone = 1'b1;
    step();
    memDone = 1'b0;
    check("wd_done_on_limit", e_dec(13'h0, 16'd10));
    Opcode = 3'b110;
    step();
    Opcode = 3'b000;
    check("wd_sw_exe", e_exe(3'd0, 0, 13'h0, 16'd10));
    step();
    check("wd_mem_enter", e_mwr(13'h0, 16'd10));
    for (int k = 1; k < TIMEOUT; k++) step();
    check("wd_mem_cycle64", e_mwr(13'h0, 16'd10));
    step();
    check("wd_fault", mk(0, 0, 0, 0, 3'd0, 0, 0, 1, 13'h0, 16'd10));
    memDone = 1'b1;
    repeat (5) step();
    check("fault_sticky", mk(0, 0, 0, 0, 3'd0, 0, 0, 1, 13'h0, 16'd10));
    memDone = 1'b0;

    // Only reset leaves FAULT
    #2 reset = 1'b0; run = 1'b0;
    #1 check("reset_clears_fault", e_idle(13'h0, 16'd0));
    #1 reset = 1'b1;
    step();
    check("idle_after_fault_reset", e_idle(13'h0, 16'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle control unit directly upstream of the CPU datapath. It owns the 13-bit program counter and sequences fetch, decode, execute, memory and writeback. It drives the datapath's memory strobes, ALU operation, operand-select and register-write signals, and consumes Opcode, memDone, BEQ and newPC back from the datapath. A memory-handshake watchdog and a retired-instruction counter are included.

Parameters:
PC_W, 13, program counter / address width
MEM_TIMEOUT, 64, maximum cycles to wait for memDone before faulting
RET_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  1 = keep executing; 0 = stop at the next instruction boundary
Opcode  in  3  decoded opcode from datapath
memDone  in  1  memory access complete, single-cycle pulse
BEQ  in  1  datapath equality flag, valid in EXECUTE
newPC  in  PC_W  branch target from datapath
read  out  1  memory read strobe
write  out  1  memory write strobe
instruction  out  1  1 = access instruction space at PC; 0 = data access at ALU result
instructionType  out  1  0 = ALU B input is sign-extended immediate; 1 = register
ALU_Op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR
writeFlag  out  1  register-file write enable
PC  out  PC_W  current program counter
busy  out  1  high in any state except IDLE and FAULT
fault  out  1  sticky memory-timeout flag
retired  out  RET_W  count of completed instructions

Behaviour:
- Opcode map: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 ADDI, 101 LW, 110 SW, 111 BEQ.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, FAULT.
- Reset (reset=0, async): state=IDLE, PC=0, retired=0, fault=0, op_q=0, watchdog=0. All strobes, writeFlag, instructionType and ALU_Op are 0.
- IDLE: all strobes 0. If run=1, go to FETCH on the next edge.
- FETCH: read=1, instruction=1. When memDone=1, go to DECODE.
- DECODE: one cycle. Latch Opcode into op_q. No strobes asserted.
- EXECUTE: one cycle. ALU_Op and instructionType are decoded from op_q:
  - R-type (000–011): ALU_Op = low 2 bits, instructionType=1.
  - ADDI, LW, SW: ADD, instructionType=0.
  - BEQ: SUB, instructionType=1.
- ALU_Op and instructionType hold from EXECUTE through MEM/WB and return to 0 in FETCH and IDLE.
- Next state from EXECUTE:
  - R-type or ADDI: go to WB.
  - LW or SW: go to MEM.
  - BEQ: PC <= (BEQ ? newPC : PC+1), retire, go to the boundary.
- MEM: instruction=0; read=1 for LW, write=1 for SW. When memDone=1:
  - LW: go to WB.
  - SW: PC <= PC+1, retire, go to the boundary.
- WB: writeFlag=1 for exactly one cycle. PC <= PC+1, retire, go to the boundary.
- Boundary: go to FETCH if run=1, else IDLE. run is sampled only here; deasserting it mid-instruction never aborts the instruction.
- PC arithmetic: modulo 2^PC_W; 8191+1 wraps to 0. A BEQ target is taken verbatim.
- retired: +1 per completed instruction, wraps at 2^RET_W.
- Watchdog:
  - Counts cycles spent in FETCH or MEM with memDone=0; clears on state entry and on memDone.
  - When the count reaches MEM_TIMEOUT, go to FAULT.
  - memDone arriving in the same cycle the limit is reached wins, and the access completes.
- FAULT: fault=1 and all strobes 0. Exit only via reset.
- memDone outside FETCH/MEM is ignored.
- read and write are never high together.
- writeFlag is never asserted outside WB.

Decomposition:
- Shared package cpu_pkg: opcode constants, ALU_Op constants, state encoding, PC_W.
- One sub-module, ctrl_decode: combinational op_q -> {ALU_Op, instructionType, is_mem, is_load, is_branch, writes_reg}.
- The FSM, PC register, watchdog and retired counter stay in the top module.

Test Plan:
- Reset/idle: reset=0 mid-FETCH, then release with run=0 -> PC=0, all outputs 0, state stays IDLE.
- ADDI sequence: run=1, memDone 2 cycles after each read, Opcode=100 -> instructionType=0, ALU_Op=000, writeFlag pulses exactly 1 cycle, PC 0->1, retired=1; fetch-to-fetch takes 6 cycles.
- LW then SW:
  - LW: MEM asserts read=1, instruction=0, then WB occurs.
  - SW: write=1, no writeFlag pulse, PC increments by 1 each, retired=2.
- BEQ: at PC=5, Opcode=111, newPC=0x100:
  - BEQ=1 -> PC=0x100, ALU_Op=001.
  - BEQ=0 -> PC=6.
  - No writeFlag pulse in either case.
- Wrap and stop: PC=8191 with ADD -> PC=0. Drop run during EXECUTE -> instruction completes, FSM parks in IDLE, busy=0.
- Watchdog:
  - memDone withheld in MEM for 64 cycles -> fault=1 stays sticky, strobes 0, FSM ignores later memDone until reset.
  - memDone on cycle 64 -> no fault.
